// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receiver: FSM state encodings, parity modes
// and a width helper used to size counters and pointers.
package uart_pkg;

  // Receiver FSM state encodings (also exported on the debug state output)
  typedef logic [2:0] rx_state_t;
  localparam rx_state_t ST_IDLE   = 3'd0;
  localparam rx_state_t ST_START  = 3'd1;
  localparam rx_state_t ST_DATA   = 3'd2;
  localparam rx_state_t ST_PARITY = 3'd3;
  localparam rx_state_t ST_STOP   = 3'd4;
  localparam rx_state_t ST_BREAK  = 3'd5;

  // Parity modes
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Bits needed to hold values 0..n-1; never less than one bit
  function automatic int width_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Host-facing bundle of the UART receiver: serial line, FIFO read port,
// per-byte error pulses and the FSM debug state.
//
// Read handshake: rd_data is valid whenever empty==0 (first-word-fall-through).
// An entry is consumed on a rising clock edge where rd_en==1 and empty==0;
// rd_en while empty is ignored. The error outputs are single-cycle pulses and
// carry no handshake.
interface uart_rx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic                 rx;
  logic                 rd_en;
  logic [DATA_BITS-1:0] rd_data;
  logic                 empty;
  logic                 full;
  logic [CW-1:0]        count;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun;
  logic [2:0]           dbg_state;

  // Host side: drives the line and pops bytes
  modport master (
    output rx, rd_en,
    input  rd_data, empty, full, count, frame_err, parity_err, overrun, dbg_state
  );

  // Receiver side
  modport slave (
    input  rx, rd_en,
    output rd_data, empty, full, count, frame_err, parity_err, overrun, dbg_state
  );
endinterface

// File: rtl/uart_rx_fifo_sync_fifo.sv
// First-word-fall-through synchronous FIFO. Pointers carry one extra bit so
// full and empty are distinguishable; a read in the same cycle as a write
// frees the slot first, so a write into a full FIFO succeeds when popped.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk_in,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = width_of(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_rd;
  logic             do_wr;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  // Head is forced to zero when empty so the output is defined out of reset
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update; both wrap naturally through the extra MSB
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset because empty masks the head
  always_ff @(posedge clk_in) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with optional parity, 1 or 2 stop bits and a
// receive FIFO. Bytes with a bad stop bit or bad parity are discarded and
// flagged; a good byte arriving at a full FIFO is dropped and flagged.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input logic           clk_in,
  input logic           rst_n,
  uart_rx_fifo_if.slave bus
);
  localparam int DIV   = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int DIV_W = width_of(DIV);
  localparam int OS_W  = width_of(OVERSAMPLE);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [OS_W-1:0]  OS_HALF   = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

  logic                   rx_meta;
  logic                   rx_sync;
  logic [DIV_W-1:0]       div_cnt;
  logic                   tick;
  rx_state_t              state;
  logic [OS_W-1:0]        os_cnt;
  logic [3:0]             bit_cnt;
  logic [DATA_BITS-1:0]   shreg;
  logic                   par_bit;
  logic                   stop_bad;
  logic                   par_calc;
  logic                   par_ok;
  logic                   push_q;
  logic                   frame_err_q;
  logic                   parity_err_q;
  logic                   overrun_q;
  logic                   fifo_full;

  // Two-flop synchroniser for the asynchronous line; idles high
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rx_sync <= rx_meta;
    end
  end

  // Free-running oversample tick divider
  always_ff @(posedge clk_in) begin
    if (!rst_n)                div_cnt <= '0;
    else if (div_cnt == DIV_LAST) div_cnt <= '0;
    else                       div_cnt <= div_cnt + 1'b1;
  end

  assign tick = (div_cnt == DIV_LAST);

  // Parity check over the received data word
  always_comb begin
    par_calc = (^shreg) ^ par_bit;
    par_ok   = 1'b1;
    if (PARITY == PAR_EVEN)     par_ok = ~par_calc;
    else if (PARITY == PAR_ODD) par_ok = par_calc;
  end

  // Receiver FSM: start validation, bit-centre sampling, frame verdict
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      os_cnt       <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      par_bit      <= 1'b0;
      stop_bad     <= 1'b0;
      push_q       <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      push_q       <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!rx_sync) begin
            os_cnt   <= '0;
            bit_cnt  <= '0;
            stop_bad <= 1'b0;
            state    <= ST_START;
          end
        end
        ST_START: begin
          if (tick) begin
            if (os_cnt == OS_HALF) begin
              os_cnt <= '0;
              // A line already high again at mid-start is a glitch
              state  <= rx_sync ? ST_IDLE : ST_DATA;
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (os_cnt == OS_LAST) begin
              os_cnt <= '0;
              shreg  <= {rx_sync, shreg[DATA_BITS-1:1]};
              if (bit_cnt == DATA_LAST) begin
                bit_cnt <= '0;
                state   <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            if (os_cnt == OS_LAST) begin
              os_cnt  <= '0;
              par_bit <= rx_sync;
              state   <= ST_STOP;
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (os_cnt == OS_LAST) begin
              os_cnt <= '0;
              if (bit_cnt == STOP_LAST) begin
                bit_cnt <= '0;
                if (stop_bad || !rx_sync) begin
                  // Frame error wins over parity; wait out a held-low line
                  frame_err_q <= 1'b1;
                  state       <= ST_BREAK;
                end else begin
                  state <= ST_IDLE;
                  if (par_ok) push_q       <= 1'b1;
                  else        parity_err_q <= 1'b1;
                end
              end else begin
                stop_bad <= stop_bad | ~rx_sync;
                bit_cnt  <= bit_cnt + 1'b1;
              end
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
        end
        ST_BREAK: begin
          if (rx_sync) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Overrun flag: a good byte met a full FIFO with no pop to make room
  always_ff @(posedge clk_in) begin
    if (!rst_n) overrun_q <= 1'b0;
    else        overrun_q <= push_q && fifo_full && !bus.rd_en;
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .wr_en   (push_q),
    .wr_data (shreg),
    .rd_en   (bus.rd_en),
    .rd_data (bus.rd_data),
    .empty   (bus.empty),
    .full    (fifo_full),
    .count   (bus.count)
  );

  assign bus.full       = fifo_full;
  assign bus.frame_err  = frame_err_q;
  assign bus.parity_err = parity_err_q;
  assign bus.overrun    = overrun_q;
  assign bus.dbg_state  = state;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo. Instance a runs the default 8N1 / 115200 setup;
// instance b runs even parity at a faster line rate (4 clocks per tick) so
// the FIFO fill/overrun scenario stays short.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int BIT_A = 432;
  localparam int BIT_B = 64;

  // ---------------- clock / reset ----------------
  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;
  always #10 clk_in = ~clk_in;

  uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) if_a ();
  uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) if_b ();

  uart_rx_fifo dut_a (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .bus    (if_a.slave)
  );

  uart_rx_fifo #(
    .CLK_HZ (50_000_000),
    .BAUD   (781_250),
    .PARITY (PAR_EVEN)
  ) dut_b (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .bus    (if_b.slave)
  );

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int fe_a = 0, pe_a = 0, ov_a = 0;
  int fe_b = 0, pe_b = 0, ov_b = 0;

  // Pulse counters sampled away from the active edge
  always @(negedge clk_in) begin
    if (if_a.frame_err === 1'b1)  fe_a++;
    if (if_a.parity_err === 1'b1) pe_a++;
    if (if_a.overrun === 1'b1)    ov_a++;
    if (if_b.frame_err === 1'b1)  fe_b++;
    if (if_b.parity_err === 1'b1) pe_b++;
    if (if_b.overrun === 1'b1)    ov_b++;
  end

  // ---------------- driver tasks ----------------
  task automatic set_rx(input int sel, input logic v);
    if (sel == 0) if_a.rx = v;
    else          if_b.rx = v;
  endtask

  task automatic drive_bit(input int sel, input logic v);
    int bc;
    bc = (sel == 0) ? BIT_A : BIT_B;
    set_rx(sel, v);
    repeat (bc) @(negedge clk_in);
  endtask

  task automatic send_frame(input int sel, input logic [7:0] data,
                            input logic with_par, input logic par_val,
                            input logic stop_val);
    drive_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(sel, data[i]);
    if (with_par) drive_bit(sel, par_val);
    drive_bit(sel, stop_val);
    set_rx(sel, 1'b1);
  endtask

  task automatic wait_nonempty(input int sel, input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_in);
      if (((sel == 0) ? if_a.empty : if_b.empty) === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_pop(input int sel, output logic [7:0] data);
    @(negedge clk_in);
    data = (sel == 0) ? if_a.rd_data : if_b.rd_data;
    if (sel == 0) if_a.rd_en = 1'b1;
    else          if_b.rd_en = 1'b1;
    @(negedge clk_in);
    if_a.rd_en = 1'b0;
    if_b.rd_en = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic e, f, fe, pe, ov;
    logic [4:0] c;
    logic [7:0] d;
    logic [2:0] st;
    rst_n = 1'b0;
    repeat (3) @(negedge clk_in);
    rst_n = 1'b1;
    @(negedge clk_in);
    for (int s = 0; s < 2; s++) begin
      e  = (s == 0) ? if_a.empty      : if_b.empty;
      f  = (s == 0) ? if_a.full       : if_b.full;
      c  = (s == 0) ? if_a.count      : if_b.count;
      d  = (s == 0) ? if_a.rd_data    : if_b.rd_data;
      st = (s == 0) ? if_a.dbg_state  : if_b.dbg_state;
      fe = (s == 0) ? if_a.frame_err  : if_b.frame_err;
      pe = (s == 0) ? if_a.parity_err : if_b.parity_err;
      ov = (s == 0) ? if_a.overrun    : if_b.overrun;
      n_checks++; if (e !== 1'b1) $display("FAIL reset_empty[%0d]: got %b want 1", s, e); else n_pass++;
      n_checks++; if (f !== 1'b0) $display("FAIL reset_full[%0d]: got %b want 0", s, f); else n_pass++;
      n_checks++; if (c !== 5'd0) $display("FAIL reset_count[%0d]: got %0d want 0", s, c); else n_pass++;
      n_checks++; if (d !== 8'h00) $display("FAIL reset_rd_data[%0d]: got %h want 00", s, d); else n_pass++;
      n_checks++; if (st !== ST_IDLE) $display("FAIL reset_state[%0d]: got %0d want %0d", s, st, ST_IDLE); else n_pass++;
      n_checks++; if ({fe, pe, ov} !== 3'b000) $display("FAIL reset_errs[%0d]: got %b want 000", s, {fe, pe, ov}); else n_pass++;
    end
  endtask

  task automatic test_single_byte();
    logic ok;
    logic [7:0] got, exp;
    exp_q.push_back(8'hA5);
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
    wait_nonempty(0, BIT_A, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL a5_arrive: got empty=%b want 0", if_a.empty); else n_pass++;
    n_checks++; if (if_a.count !== 5'd1) $display("FAIL a5_count: got %0d want 1", if_a.count); else n_pass++;
    do_pop(0, got);
    exp = exp_q.pop_front();
    n_checks++; if (got !== exp) $display("FAIL a5_data: got %h want %h", got, exp); else n_pass++;
    n_checks++; if (if_a.empty !== 1'b1) $display("FAIL a5_empty_after_pop: got %b want 1", if_a.empty); else n_pass++;
    n_checks++; if (if_a.count !== 5'd0) $display("FAIL a5_count_after_pop: got %0d want 0", if_a.count); else n_pass++;
  endtask

  task automatic test_glitch();
    int fe0, pe0;
    fe0 = fe_a;
    pe0 = pe_a;
    if_a.rx = 1'b0;
    repeat (50) @(negedge clk_in);
    n_checks++; if (if_a.dbg_state !== ST_START) $display("FAIL glitch_in_start: got %0d want %0d", if_a.dbg_state, ST_START); else n_pass++;
    repeat (50) @(negedge clk_in);
    if_a.rx = 1'b1;
    repeat (600) @(negedge clk_in);
    n_checks++; if (if_a.dbg_state !== ST_IDLE) $display("FAIL glitch_state: got %0d want %0d", if_a.dbg_state, ST_IDLE); else n_pass++;
    n_checks++; if (if_a.empty !== 1'b1) $display("FAIL glitch_empty: got %b want 1", if_a.empty); else n_pass++;
    n_checks++; if ((fe_a - fe0) + (pe_a - pe0) !== 0) $display("FAIL glitch_errs: got %0d want 0", (fe_a - fe0) + (pe_a - pe0)); else n_pass++;
  endtask

  task automatic test_frame_err();
    int fe0, pe0;
    logic ok;
    logic [7:0] got, exp;
    fe0 = fe_a;
    pe0 = pe_a;
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0);
    repeat (BIT_A) @(negedge clk_in);
    n_checks++; if (fe_a - fe0 !== 1) $display("FAIL frame_err_pulses: got %0d want 1", fe_a - fe0); else n_pass++;
    n_checks++; if (pe_a - pe0 !== 0) $display("FAIL frame_err_no_parity: got %0d want 0", pe_a - pe0); else n_pass++;
    n_checks++; if (if_a.empty !== 1'b1) $display("FAIL frame_err_empty: got %b want 1", if_a.empty); else n_pass++;
    n_checks++; if (if_a.dbg_state !== ST_IDLE) $display("FAIL frame_err_state: got %0d want %0d", if_a.dbg_state, ST_IDLE); else n_pass++;
    exp_q.push_back(8'h3C);
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
    wait_nonempty(0, BIT_A, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL frame_err_recover: got empty=%b want 0", if_a.empty); else n_pass++;
    do_pop(0, got);
    exp = exp_q.pop_front();
    n_checks++; if (got !== exp) $display("FAIL frame_err_recover_data: got %h want %h", got, exp); else n_pass++;
  endtask

  task automatic test_parity();
    int pe0, fe0;
    logic ok;
    logic [7:0] got, exp;
    pe0 = pe_b;
    fe0 = fe_b;
    // 0x03 has two ones: even parity bit must be 0
    send_frame(1, 8'h03, 1'b1, 1'b1, 1'b1);
    repeat (BIT_B) @(negedge clk_in);
    n_checks++; if (pe_b - pe0 !== 1) $display("FAIL parity_err_pulses: got %0d want 1", pe_b - pe0); else n_pass++;
    n_checks++; if (fe_b - fe0 !== 0) $display("FAIL parity_no_frame_err: got %0d want 0", fe_b - fe0); else n_pass++;
    n_checks++; if (if_b.empty !== 1'b1) $display("FAIL parity_bad_empty: got %b want 1", if_b.empty); else n_pass++;
    exp_q.push_back(8'h03);
    send_frame(1, 8'h03, 1'b1, 1'b0, 1'b1);
    wait_nonempty(1, BIT_B, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL parity_good_arrive: got empty=%b want 0", if_b.empty); else n_pass++;
    do_pop(1, got);
    exp = exp_q.pop_front();
    n_checks++; if (got !== exp) $display("FAIL parity_good_data: got %h want %h", got, exp); else n_pass++;
  endtask

  task automatic test_fill_overrun();
    int ov0, exp_ovr;
    logic [7:0] d, got, exp;
    ov0 = ov_b;
    exp_ovr = 0;
    for (int i = 0; i < 17; i++) begin
      d = 8'(i);
      if (exp_q.size() < 16) exp_q.push_back(d);
      else                   exp_ovr++;
      send_frame(1, d, 1'b1, ^d, 1'b1);
      repeat (BIT_B) @(negedge clk_in);
      if (i == 15) begin
        n_checks++; if (if_b.full !== 1'b1) $display("FAIL fill_full: got %b want 1", if_b.full); else n_pass++;
        n_checks++; if (if_b.count !== 5'd16) $display("FAIL fill_count: got %0d want 16", if_b.count); else n_pass++;
      end
    end
    n_checks++; if (ov_b - ov0 !== exp_ovr) $display("FAIL overrun_pulses: got %0d want %0d", ov_b - ov0, exp_ovr); else n_pass++;
    n_checks++; if (if_b.count !== 5'd16) $display("FAIL overrun_count: got %0d want 16", if_b.count); else n_pass++;
    while (exp_q.size() > 0) begin
      do_pop(1, got);
      exp = exp_q.pop_front();
      n_checks++; if (got !== exp) $display("FAIL fill_read: got %h want %h", got, exp); else n_pass++;
    end
    n_checks++; if (if_b.empty !== 1'b1) $display("FAIL fill_drained_empty: got %b want 1", if_b.empty); else n_pass++;
    n_checks++; if (if_b.full !== 1'b0) $display("FAIL fill_drained_full: got %b want 0", if_b.full); else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    logic ok;
    logic [7:0] got, exp;
    int fe0, pe0;
    // Leave one byte in the FIFO so the reset has contents to discard
    send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1);
    wait_nonempty(0, BIT_A, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL rst_pre_byte: got empty=%b want 0", if_a.empty); else n_pass++;
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    n_checks++; if (if_a.dbg_state !== ST_DATA) $display("FAIL rst_in_data: got %0d want %0d", if_a.dbg_state, ST_DATA); else n_pass++;
    fe0 = fe_a;
    pe0 = pe_a;
    rst_n   = 1'b0;
    if_a.rx = 1'b1;
    repeat (2) @(negedge clk_in);
    rst_n = 1'b1;
    n_checks++; if (if_a.empty !== 1'b1) $display("FAIL rst_mid_empty: got %b want 1", if_a.empty); else n_pass++;
    n_checks++; if (if_a.count !== 5'd0) $display("FAIL rst_mid_count: got %0d want 0", if_a.count); else n_pass++;
    n_checks++; if (if_a.rd_data !== 8'h00) $display("FAIL rst_mid_rd_data: got %h want 00", if_a.rd_data); else n_pass++;
    n_checks++; if (if_a.dbg_state !== ST_IDLE) $display("FAIL rst_mid_state: got %0d want %0d", if_a.dbg_state, ST_IDLE); else n_pass++;
    exp_q.delete();
    repeat (2 * BIT_A) @(negedge clk_in);
    n_checks++; if ((fe_a - fe0) + (pe_a - pe0) !== 0) $display("FAIL rst_mid_errs: got %0d want 0", (fe_a - fe0) + (pe_a - pe0)); else n_pass++;
    exp_q.push_back(8'h5A);
    send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1);
    wait_nonempty(0, BIT_A, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL rst_post_arrive: got empty=%b want 0", if_a.empty); else n_pass++;
    n_checks++; if (if_a.count !== 5'd1) $display("FAIL rst_post_count: got %0d want 1", if_a.count); else n_pass++;
    do_pop(0, got);
    exp = exp_q.pop_front();
    n_checks++; if (got !== exp) $display("FAIL rst_post_data: got %h want %h", got, exp); else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    if_a.rx = 1'b1; if_a.rd_en = 1'b0;
    if_b.rx = 1'b1; if_b.rd_en = 1'b0;
    test_reset();
    test_single_byte();
    test_glitch();
    test_frame_err();
    test_parity();
    test_fill_overrun();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog: bounded run time
  initial begin
    #3_000_000;
    $display("FAIL watchdog: run exceeded time limit, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
